sd_host_xfer_sequencer: RTL and testbench

Controller that turns one high-level block-transfer request into the ordered register-write sequence the SD Host needs: block size, block count, transfer mode, argument low/high, then command. The command write sets start_flag. The block then waits for command and transfer completion, with a timeout, and reports done or error to the requester. It sits between a system-side requester (CPU model or DMA engine) and the SD Host register port (reg_address / reg_wr_data / reg_wr_en / req).

---
 rtl/sd_host_xfer_sequencer_pkg.sv | 78 +++++++
 rtl/sd_seq_timeout_counter.sv | 31 +++
 rtl/sd_host_xfer_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_sd_host_xfer_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_host_xfer_sequencer_pkg.sv
// Shared types and constants for the SD Host transfer sequencer:
// register offsets, command indices, error codes, FSM states, helpers.
package sd_host_xfer_sequencer_pkg;

    localparam logic [31:0] REG_BLK_SIZE = 32'h0000_0004;
    localparam logic [31:0] REG_BLK_CNT  = 32'h0000_0006;
    localparam logic [31:0] REG_ARG_LO   = 32'h0000_0008;
    localparam logic [31:0] REG_ARG_HI   = 32'h0000_000A;
    localparam logic [31:0] REG_TMODE    = 32'h0000_000C;
    localparam logic [31:0] REG_CMD      = 32'h0000_000E;

    localparam logic [5:0] CMD_RD_SINGLE = 6'd17;
    localparam logic [5:0] CMD_RD_MULTI  = 6'd18;
    localparam logic [5:0] CMD_WR_SINGLE = 6'd24;
    localparam logic [5:0] CMD_WR_MULTI  = 6'd25;

    localparam logic [11:0] MAX_BLK_SIZE = 12'd2048;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_HOST    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_BAD_REQ = 2'd3
    } err_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_BSIZE  = 4'd1,
        ST_WR_BCNT   = 4'd2,
        ST_WR_TMODE  = 4'd3,
        ST_WR_ARG_LO = 4'd4,
        ST_WR_ARG_HI = 4'd5,
        ST_WR_CMD    = 4'd6,
        ST_WAIT_CMD  = 4'd7,
        ST_WAIT_XFER = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    typedef struct packed {
        logic        dir;
        logic [31:0] arg;
        logic [11:0] blk_size;
        logic [15:0] blk_cnt;
    } xfer_req_t;

    function automatic logic bad_request(
        input logic [11:0] size,
        input logic [15:0] cnt
    );
        return (cnt == 16'd0) || (size == 12'd0) ||
               (size > MAX_BLK_SIZE);
    endfunction

    function automatic logic [5:0] cmd_index(
        input logic        dir,
        input logic [15:0] cnt
    );
        logic multi;
        multi = (cnt > 16'd1);
        if (dir)
            return multi ? CMD_RD_MULTI : CMD_RD_SINGLE;
        return multi ? CMD_WR_MULTI : CMD_WR_SINGLE;
    endfunction

    // Read sets bit4; a single block drops the Multiple flag (bit5).
    function automatic logic [7:0] tmode_value(
        input logic        dir,
        input logic [15:0] cnt,
        input logic [7:0]  flags
    );
        logic [7:0] v;
        v = flags | {3'b000, dir, 4'b0000};
        if (cnt <= 16'd1)
            v[5] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/sd_seq_timeout_counter.sv
// Wait-state timeout counter: clear restarts at 0, enable counts up.
// Ports: CLK, RESET (async low), clear, enable -> expired (count==LAST).
module sd_seq_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == LAST);

    // Saturates at LAST so a stalled owner never sees a wrap.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/sd_host_xfer_sequencer.sv
// Turns one block-transfer request into the SD Host register write
// sequence, then waits for command/transfer completion with timeout.
// Ports: xfer_* requester side, reg_* / req SD Host register port,
// cmd_complete / xfer_complete / host_error host status,
// busy / done / err_code completion report.
module sd_host_xfer_sequencer
    import sd_host_xfer_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  TMODE_FLAGS    = 8'h23,
    parameter logic [7:0]  CMD_FLAGS      = 8'h33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        xfer_start,
    output logic        xfer_ready,
    input  logic        xfer_dir,
    input  logic [31:0] xfer_arg,
    input  logic [11:0] xfer_blk_size,
    input  logic [15:0] xfer_blk_cnt,
    output logic [31:0] reg_address,
    output logic [31:0] reg_wr_data,
    output logic        reg_wr_en,
    output logic        req,
    input  logic        reg_ack,
    input  logic        cmd_complete,
    input  logic        xfer_complete,
    input  logic        host_error,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

    state_e    state;
    state_e    state_next;
    xfer_req_t req_q;
    xfer_req_t cur;
    err_e      err_next;
    logic      err_load;
    logic      accept;
    logic      in_wr;
    logic      in_wait;
    logic      wait_clear;
    logic      expired;
    logic        req_d;
    logic [31:0] addr_d;
    logic [31:0] data_d;

    assign accept = (state == ST_IDLE) && xfer_start;

    assign in_wr = (state == ST_WR_BSIZE)  ||
                   (state == ST_WR_BCNT)   ||
                   (state == ST_WR_TMODE)  ||
                   (state == ST_WR_ARG_LO) ||
                   (state == ST_WR_ARG_HI) ||
                   (state == ST_WR_CMD);

    assign in_wait = (state == ST_WAIT_CMD) ||
                     (state == ST_WAIT_XFER);

    assign wait_clear = (state_next != state) &&
                        ((state_next == ST_WAIT_CMD) ||
                         (state_next == ST_WAIT_XFER));

    // Outputs are registered from the next state, so on the accept
    // edge the request fields must come straight from the inputs.
    assign cur = (state == ST_IDLE) ?
        {xfer_dir, xfer_arg, xfer_blk_size, xfer_blk_cnt} : req_q;

    sd_seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (wait_clear),
        .enable (in_wait),
        .expired(expired)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
            req_q <= '0;
        end else begin
            state <= state_next;
            if (accept)
                req_q <= cur;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = ERR_OK;
        err_load   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (xfer_start) begin
                    err_load = 1'b1;
                    if (bad_request(cur.blk_size, cur.blk_cnt)) begin
                        state_next = ST_DONE;
                        err_next   = ERR_BAD_REQ;
                    end else begin
                        state_next = ST_WR_BSIZE;
                    end
                end
            end
            ST_WR_BSIZE:  if (reg_ack) state_next = ST_WR_BCNT;
            ST_WR_BCNT:   if (reg_ack) state_next = ST_WR_TMODE;
            ST_WR_TMODE:  if (reg_ack) state_next = ST_WR_ARG_LO;
            ST_WR_ARG_LO: if (reg_ack) state_next = ST_WR_ARG_HI;
            ST_WR_ARG_HI: if (reg_ack) state_next = ST_WR_CMD;
            ST_WR_CMD:    if (reg_ack) state_next = ST_WAIT_CMD;
            ST_WAIT_CMD: begin
                if (cmd_complete && xfer_complete) begin
                    state_next = ST_DONE;
                    err_load   = 1'b1;
                end else if (cmd_complete) begin
                    state_next = ST_WAIT_XFER;
                end else if (expired) begin
                    state_next = ST_DONE;
                    err_next   = ERR_TIMEOUT;
                    err_load   = 1'b1;
                end
            end
            ST_WAIT_XFER: begin
                if (xfer_complete) begin
                    state_next = ST_DONE;
                    err_load   = 1'b1;
                end else if (expired) begin
                    state_next = ST_DONE;
                    err_next   = ERR_TIMEOUT;
                    err_load   = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // Host error outranks any completion or timeout this cycle.
        if (host_error && (in_wr || in_wait)) begin
            state_next = ST_DONE;
            err_next   = ERR_HOST;
            err_load   = 1'b1;
        end
    end

    always_comb begin
        req_d  = 1'b0;
        addr_d = '0;
        data_d = '0;
        unique case (1'b1)
            (state_next == ST_WR_BSIZE): begin
                req_d  = 1'b1;
                addr_d = REG_BLK_SIZE;
                data_d = {20'h0, cur.blk_size};
            end
            (state_next == ST_WR_BCNT): begin
                req_d  = 1'b1;
                addr_d = REG_BLK_CNT;
                data_d = {16'h0, cur.blk_cnt};
            end
            (state_next == ST_WR_TMODE): begin
                req_d  = 1'b1;
                addr_d = REG_TMODE;
                data_d = {24'h0, tmode_value(cur.dir,
                                             cur.blk_cnt,
                                             TMODE_FLAGS)};
            end
            (state_next == ST_WR_ARG_LO): begin
                req_d  = 1'b1;
                addr_d = REG_ARG_LO;
                data_d = {16'h0, cur.arg[15:0]};
            end
            (state_next == ST_WR_ARG_HI): begin
                req_d  = 1'b1;
                addr_d = REG_ARG_HI;
                data_d = {16'h0, cur.arg[31:16]};
            end
            (state_next == ST_WR_CMD): begin
                req_d  = 1'b1;
                addr_d = REG_CMD;
                data_d = {16'h0, 2'b00,
                          cmd_index(cur.dir, cur.blk_cnt),
                          CMD_FLAGS};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            req         <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_address <= '0;
            reg_wr_data <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            xfer_ready  <= 1'b1;
            err_code    <= ERR_OK;
        end else begin
            req         <= req_d;
            reg_wr_en   <= req_d;
            reg_address <= addr_d;
            reg_wr_data <= data_d;
            done        <= (state_next == ST_DONE);
            busy        <= (state_next != ST_IDLE);
            xfer_ready  <= (state_next == ST_IDLE);
            if (err_load)
                err_code <= err_next;
        end
    end

endmodule

// File: tb/tb_sd_host_xfer_sequencer.sv
// Bench for sd_host_xfer_sequencer: table vectors, random requests
// against a cycle-schedule model, and reset / DONE corner sequences.
module tb_sd_host_xfer_sequencer;

    localparam int T = 16;

    logic        CLK;
    logic        RESET;
    logic        xfer_start;
    logic        xfer_ready;
    logic        xfer_dir;
    logic [31:0] xfer_arg;
    logic [11:0] xfer_blk_size;
    logic [15:0] xfer_blk_cnt;
    logic [31:0] reg_address;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic        req;
    logic        reg_ack;
    logic        cmd_complete;
    logic        xfer_complete;
    logic        host_error;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int test_id = 0;

    sd_host_xfer_sequencer #(
        .TIMEOUT_CYCLES(T),
        .TMODE_FLAGS   (8'h23),
        .CMD_FLAGS     (8'h33)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .xfer_start   (xfer_start),
        .xfer_ready   (xfer_ready),
        .xfer_dir     (xfer_dir),
        .xfer_arg     (xfer_arg),
        .xfer_blk_size(xfer_blk_size),
        .xfer_blk_cnt (xfer_blk_cnt),
        .reg_address  (reg_address),
        .reg_wr_data  (reg_wr_data),
        .reg_wr_en    (reg_wr_en),
        .req          (req),
        .reg_ack      (reg_ack),
        .cmd_complete (cmd_complete),
        .xfer_complete(xfer_complete),
        .host_error   (host_error),
        .busy         (busy),
        .done         (done),
        .err_code     (err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        dir;
        logic [31:0] arg;
        logic [11:0] size;
        logic [15:0] cnt;
        int          stall;
        int          cmd_dly;
        int          xfer_dly;
        bit          both;
        bit          herr;
        logic [7:0]  tmode;
        logic [15:0] cmdw;
        logic [1:0]  err;
        int          done_k;
    } vec_t;

    typedef struct {
        bit              bad;
        logic [5:0][31:0] wa;
        logic [5:0][31:0] wd;
        logic [1:0]      err;
        int              done_k;
    } exp_t;

    vec_t tbl[13];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL t%0d %s: got 0x%0h expected 0x%0h",
                     test_id, name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic dir, input logic [31:0] arg,
        input logic [11:0] size, input logic [15:0] cnt,
        input int stall, input int cmd_dly, input int xfer_dly,
        input bit both, input bit herr,
        input logic [7:0] tmode, input logic [15:0] cmdw,
        input logic [1:0] err, input int done_k);
        vec_t v;
        v.dir = dir; v.arg = arg; v.size = size; v.cnt = cnt;
        v.stall = stall; v.cmd_dly = cmd_dly;
        v.xfer_dly = xfer_dly; v.both = both; v.herr = herr;
        v.tmode = tmode; v.cmdw = cmdw; v.err = err;
        v.done_k = done_k;
        return v;
    endfunction

    // Reference: write list from the register map, completion cycle
    // (relative to the accept edge) from the wait/timeout rules.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        bit multi;
        int entry, ck, xe;
        logic [5:0] idx;
        e.bad = (v.cnt == 0) || (v.size == 0) || (v.size > 2048);
        multi = (v.cnt > 1);
        idx = 6'(v.dir ? (multi ? 18 : 17) : (multi ? 25 : 24));
        e.wa[0] = 32'h004; e.wd[0] = {20'h0, v.size};
        e.wa[1] = 32'h006; e.wd[1] = {16'h0, v.cnt};
        e.wa[2] = 32'h00C;
        e.wd[2] = v.dir ? (multi ? 32'h33 : 32'h13)
                        : (multi ? 32'h23 : 32'h03);
        e.wa[3] = 32'h008; e.wd[3] = {16'h0, v.arg[15:0]};
        e.wa[4] = 32'h00A; e.wd[4] = {16'h0, v.arg[31:16]};
        e.wa[5] = 32'h00E; e.wd[5] = {16'h0, 2'b00, idx, 8'h33};
        if (e.bad) begin
            e.err = 2'd3;
            e.done_k = 1;
        end else begin
            entry = 1 + 6 * (v.stall + 1);
            if (v.cmd_dly < T) begin
                ck = entry + v.cmd_dly;
                if (v.both) begin
                    e.done_k = ck + 1;
                    e.err = v.herr ? 2'd1 : 2'd0;
                end else begin
                    xe = ck + 1;
                    if (v.xfer_dly < T) begin
                        e.done_k = xe + v.xfer_dly + 1;
                        e.err = v.herr ? 2'd1 : 2'd0;
                    end else begin
                        e.done_k = xe + T;
                        e.err = 2'd2;
                    end
                end
            end else begin
                e.done_k = entry + T;
                e.err = 2'd2;
            end
        end
        return e;
    endfunction

    task automatic idle_inputs();
        xfer_start = 0; reg_ack = 0;
        cmd_complete = 0; xfer_complete = 0; host_error = 0;
    endtask

    task automatic run_vec(input vec_t v, input bit use_tbl);
        exp_t e;
        int per, nw, cmd_k, xfer_k, w, j;
        e = model(v);
        if (use_tbl) begin
            e.wd[2] = {24'h0, v.tmode};
            e.wd[5] = {16'h0, v.cmdw};
            e.err = v.err;
            e.done_k = v.done_k;
        end
        per = v.stall + 1;
        nw = e.bad ? 0 : 6 * per;
        cmd_k = e.bad ? -1 : 1 + nw + v.cmd_dly;
        xfer_k = e.bad ? -1 : (v.both ? cmd_k : cmd_k + 1 + v.xfer_dly);
        w = 0;
        while (!xfer_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("ready_before", 32'(xfer_ready), 32'd1);
        xfer_dir = v.dir; xfer_arg = v.arg;
        xfer_blk_size = v.size; xfer_blk_cnt = v.cnt;
        idle_inputs();
        xfer_start = 1;
        for (int k = 1; k <= e.done_k + 1; k++) begin
            @(negedge CLK);
            xfer_start = 0;
            if (k <= nw) begin
                j = (k - 1) / per;
                check("wr_req", 32'({reg_wr_en, req}), 32'd3);
                check("wr_addr", reg_address, e.wa[j]);
                check("wr_data", reg_wr_data, e.wd[j]);
                reg_ack = (((k - 1) % per) == per - 1);
            end else begin
                check("no_req", 32'({reg_wr_en, req}), 32'd0);
                reg_ack = 0;
            end
            check("done", 32'(done), 32'(k == e.done_k));
            check("busy", 32'(busy), 32'(k <= e.done_k));
            if (k >= e.done_k)
                check("err_code", 32'(err_code), 32'(e.err));
            if (k == e.done_k + 1)
                check("ready_after", 32'(xfer_ready), 32'd1);
            cmd_complete = (k == cmd_k);
            xfer_complete = (k == xfer_k);
            host_error = v.herr && (k == xfer_k);
        end
        idle_inputs();
    endtask

    initial begin
        tbl[0]  = mk(1, 32'h8310_2140, 64, 10, 0, 3, 5, 0, 0,
                     8'h33, 16'h1233, 0, 17);
        tbl[1]  = mk(0, 32'h7654_3210, 512, 8, 3, 2, 2, 0, 0,
                     8'h23, 16'h1933, 0, 31);
        tbl[2]  = mk(1, 32'h0000_1000, 512, 1, 1, 0, 0, 0, 0,
                     8'h13, 16'h1133, 0, 15);
        tbl[3]  = mk(0, 32'hFFFF_FFFF, 2048, 1, 0, 1, 0, 1, 0,
                     8'h03, 16'h1833, 0, 9);
        tbl[4]  = mk(1, 32'h0000_1234, 64, 0, 0, 0, 0, 0, 0,
                     8'h00, 16'h0000, 3, 1);
        tbl[5]  = mk(0, 32'h0000_1234, 0, 5, 0, 0, 0, 0, 0,
                     8'h00, 16'h0000, 3, 1);
        tbl[6]  = mk(1, 32'h0000_1234, 2049, 5, 0, 0, 0, 0, 0,
                     8'h00, 16'h0000, 3, 1);
        tbl[7]  = mk(0, 32'h0000_0200, 512, 2, 0, 99, 0, 0, 0,
                     8'h23, 16'h1933, 2, 23);
        tbl[8]  = mk(1, 32'h0000_0300, 1024, 3, 0, 15, 4, 0, 0,
                     8'h33, 16'h1233, 0, 28);
        tbl[9]  = mk(0, 32'hABCD_0001, 16, 4, 0, 0, 99, 0, 0,
                     8'h23, 16'h1933, 2, 24);
        tbl[10] = mk(1, 32'h5555_AAAA, 16, 16'hFFFF, 0, 0, 15, 0, 0,
                     8'h33, 16'h1233, 0, 24);
        tbl[11] = mk(0, 32'h0BAD_F00D, 512, 3, 0, 0, 2, 0, 1,
                     8'h23, 16'h1933, 1, 11);
        tbl[12] = mk(0, 32'h0000_0042, 1, 1, 0, 16, 0, 0, 0,
                     8'h03, 16'h1833, 2, 23);

        RESET = 1;
        xfer_dir = 0; xfer_arg = 0; xfer_blk_size = 0; xfer_blk_cnt = 0;
        idle_inputs();
        #3 RESET = 0;
        #1;
        check("rst_req", 32'({reg_wr_en, req}), 32'd0);
        check("rst_done_busy", 32'({done, busy}), 32'd0);
        check("rst_addr", reg_address, 32'd0);
        check("rst_data", reg_wr_data, 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_ready", 32'(xfer_ready), 32'd1);
        repeat (2) @(negedge CLK);
        RESET = 1;
        @(negedge CLK);

        for (int i = 0; i < 13; i++) begin
            test_id = i;
            run_vec(tbl[i], 1'b1);
        end

        test_id = 100;
        xfer_dir = 0; xfer_arg = 32'h1; xfer_blk_size = 64;
        xfer_blk_cnt = 0;
        xfer_start = 1;
        @(negedge CLK);
        check("bad_done", 32'({done, err_code}), 32'b111);
        xfer_blk_cnt = 4;
        @(negedge CLK);
        xfer_start = 0;
        check("done_ignore_ready", 32'(xfer_ready), 32'd1);
        check("done_ignore_busy", 32'({busy, req}), 32'd0);
        check("err_hold", 32'(err_code), 32'd3);
        @(negedge CLK);
        check("still_idle", 32'(xfer_ready), 32'd1);

        test_id = 101;
        xfer_dir = 1; xfer_arg = 32'h2222_1111; xfer_blk_size = 8;
        xfer_blk_cnt = 2;
        xfer_start = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            xfer_start = 0;
            reg_ack = 1;
        end
        check("pre_rst_addr", reg_address, 32'h008);
        check("pre_rst_data", reg_wr_data, 32'h1111);
        RESET = 0;
        #1;
        check("mid_rst_req", 32'({reg_wr_en, req}), 32'd0);
        check("mid_rst_ready", 32'({xfer_ready, busy}), 32'b10);
        check("mid_rst_addr", reg_address, 32'd0);
        @(negedge CLK);
        RESET = 1;
        reg_ack = 0;
        @(negedge CLK);
        check("post_rst_idle", 32'({xfer_ready, req}), 32'b10);
        test_id = 102;
        run_vec(tbl[0], 1'b1);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int r;
            test_id = 200 + i;
            v.dir = 1'($urandom_range(0, 1));
            v.arg = $urandom;
            v.size = 12'($urandom_range(0, 2200));
            r = $urandom_range(0, 5);
            if (r == 0) v.cnt = 0;
            else if (r == 1) v.cnt = 1;
            else v.cnt = 16'($urandom_range(2, 65535));
            v.stall = $urandom_range(0, 3);
            v.cmd_dly = $urandom_range(0, 18);
            v.xfer_dly = $urandom_range(0, 18);
            v.both = ($urandom_range(0, 7) == 0);
            v.herr = ($urandom_range(0, 9) == 0);
            v.tmode = 0; v.cmdw = 0; v.err = 0; v.done_k = 0;
            run_vec(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
